bram_sdp_param: RTL and testbench



---
 rtl/bram_sdp_param.sv | 139 +++++++++++++
 tb/tb_bram_sdp_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_param.sv
// bram_sdp_param
// Simple dual-port block RAM with one clock and per-lane write enables.
// The write port and the read port may target the same word in one cycle.
// In that case the read returns the old contents and flags a collision.
//
// Build option:
//   BRAM_SDP_DOREG_EN  When defined, an output register follows the read latch.
//                      The register advances only while regce=1, so read
//                      latency becomes 2. When undefined, the latch drives the
//                      outputs directly, regce is ignored and latency is 1.
//
// Parameters:
//   DATA_W  word width in bits (9, 18, 36 or 72)
//   ADDR_W  word address width; depth is 2**ADDR_W
//   SRVAL   value shown on rd_data after rst_n or rd_rst
//   NBE     number of 9-bit byte lanes (derived from DATA_W)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset (clears the read pipeline only)
//   wr_en      write enable
//   wr_addr    write word address
//   wr_be      per-lane write enables
//   wr_data    write data
//   rd_en      read enable
//   rd_addr    read word address
//   rd_rst     synchronous reset of the read output to SRVAL
//   regce      output-register clock enable
//   rd_data    read data
//   rd_valid   one-cycle pulse for each new read result
//   collision  read hit the word written in the same cycle (aligned with rd_valid)
module bram_sdp_param #(
  parameter int                DATA_W = 72,
  parameter int                ADDR_W = 9,
  parameter logic [DATA_W-1:0] SRVAL  = '0,
  localparam int               NBE    = DATA_W / 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NBE-1:0]    wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rst,
  input  logic              regce,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;

  // Memory array. It has no reset, so its contents survive rst_n.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin : write_port
    for (int i = 0; i < NBE; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[wr_addr][i*9 +: 9] <= wr_data[i*9 +: 9];
      end
    end
  end

  // A write with no lanes enabled changes nothing, so it does not count as a collision.
  logic hit;
  assign hit = rd_en & wr_en & (|wr_be) & (rd_addr == wr_addr);

  logic [DATA_W-1:0] lat_data;
  logic              lat_valid;
  logic              lat_coll;
  logic              lat_take;

`ifdef BRAM_SDP_DOREG_EN
  // A latched result stays pending until the output register takes it.
  // This way a stall on regce cannot drop the result.
  assign lat_take = regce;
`else
  assign lat_take = 1'b1;
  logic unused_regce;
  assign unused_regce = regce;
`endif

  // Read latch. The memory is sampled before this edge's write lands,
  // so a same-address read returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin : read_latch
    if (!rst_n) begin
      lat_data  <= SRVAL;
      lat_valid <= 1'b0;
      lat_coll  <= 1'b0;
    end else if (rd_rst) begin
      lat_data  <= SRVAL;
      lat_valid <= 1'b0;
      lat_coll  <= 1'b0;
    end else if (rd_en) begin
      lat_data  <= mem[rd_addr];
      lat_valid <= 1'b1;
      lat_coll  <= hit;
    end else if (lat_take) begin
      lat_valid <= 1'b0;
      lat_coll  <= 1'b0;
    end
  end

`ifdef BRAM_SDP_DOREG_EN
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_coll;

  // Output register. While regce=0 everything holds.
  // The latch valid is cleared once it has been taken.
  // So a held result produces only one rd_valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin : out_reg
    if (!rst_n) begin
      out_data  <= SRVAL;
      out_valid <= 1'b0;
      out_coll  <= 1'b0;
    end else if (rd_rst) begin
      out_data  <= SRVAL;
      out_valid <= 1'b0;
      out_coll  <= 1'b0;
    end else if (regce) begin
      out_data  <= lat_data;
      out_valid <= lat_valid;
      out_coll  <= lat_coll;
    end
  end

  assign rd_data   = out_data;
  assign rd_valid  = out_valid;
  assign collision = out_coll;
`else
  assign rd_data   = lat_data;
  assign rd_valid  = lat_valid;
  assign collision = lat_coll;
`endif

endmodule

// File: tb/tb_bram_sdp_param.sv
// Directed testbench for bram_sdp_param (DATA_W=72, ADDR_W=9, SRVAL=0x0F).
// Works with or without BRAM_SDP_DOREG_EN. The expected read latency follows the build option.
module tb_bram_sdp_param;

`ifdef BRAM_SDP_DOREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [71:0] SRV   = 72'h0F;
  localparam logic [71:0] D24   = 72'h123456789ABCDEF012;
  localparam logic [71:0] ONES  = {72{1'b1}};
  localparam logic [71:0] LANE0 = 72'h0000000000000001FF;
  localparam logic [71:0] AAS   = 72'hAAAAAAAAAAAAAAAAAA;
  localparam logic [71:0] FIVES = 72'h555555555555555555;
  localparam logic [71:0] W511  = 72'hFEDCBA9876543210AB;
  localparam logic [71:0] W0    = 72'h0F0E0D0C0B0A090807;
  localparam logic [71:0] W1    = 72'h111122223333444455;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_be;
  logic [71:0] wr_data;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic        rd_rst;
  logic        regce;
  logic [71:0] rd_data;
  logic        rd_valid;
  logic        collision;

  int checks = 0;
  int errors = 0;

  bram_sdp_param #(
    .DATA_W (72),
    .ADDR_W (9),
    .SRVAL  (SRV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_rst    (rd_rst),
    .regce     (regce),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .collision (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access cycle, then idle until the result reaches the outputs.
  task automatic access(input logic re, input logic [8:0] ra,
                        input logic we, input logic [8:0] wa,
                        input logic [7:0] be, input logic [71:0] wd);
    rd_en = re; rd_addr = ra;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; wr_be = '0;
    for (int i = 1; i < LAT; i++) tick();
  endtask

  task automatic do_write(input logic [8:0] a, input logic [7:0] be, input logic [71:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic do_read(input logic [8:0] a);
    access(1'b1, a, 1'b0, 9'd0, 8'h00, 72'h0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_rst = 1'b0; regce = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", rd_data, SRV);
    chk("rst_valid", {71'b0, rd_valid}, 72'h0);
    chk("rst_coll", {71'b0, collision}, 72'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // full-width write then read at the next edge
    do_write(9'd5, 8'hFF, D24);
    do_read(9'd5);
    chk("full_data", rd_data, D24);
    chk("full_valid", {71'b0, rd_valid}, 72'h1);
    chk("full_coll", {71'b0, collision}, 72'h0);
    tick();
    chk("full_pulse_end", {71'b0, rd_valid}, 72'h0);
    chk("latch_hold", rd_data, D24);

    // single-lane write
    do_write(9'd7, 8'hFF, 72'h0);
    do_write(9'd7, 8'h01, ONES);
    do_read(9'd7);
    chk("lane0_data", rd_data, LANE0);

    // same-address access with wr_be=0: not a collision, and nothing is written
    access(1'b1, 9'd7, 1'b1, 9'd7, 8'h00, ONES);
    chk("be0_data", rd_data, LANE0);
    chk("be0_coll", {71'b0, collision}, 72'h0);
    do_read(9'd7);
    chk("be0_nowrite", rd_data, LANE0);

    // read-first collision
    do_write(9'd3, 8'hFF, AAS);
    access(1'b1, 9'd3, 1'b1, 9'd3, 8'hFF, FIVES);
    chk("coll_old_data", rd_data, AAS);
    chk("coll_flag", {71'b0, collision}, 72'h1);
    chk("coll_valid", {71'b0, rd_valid}, 72'h1);
    do_read(9'd3);
    chk("coll_new_data", rd_data, FIVES);
    chk("coll_clear", {71'b0, collision}, 72'h0);

    // back-to-back reads: one result per cycle
    for (int t = 0; t < 4; t++) begin
      rd_en = (t < 2);
      rd_addr = (t == 0) ? 9'd5 : 9'd7;
      tick();
      if (t == LAT - 1) begin
        chk("cont_d0", rd_data, D24);
        chk("cont_v0", {71'b0, rd_valid}, 72'h1);
      end else if (t == LAT) begin
        chk("cont_d1", rd_data, LANE0);
        chk("cont_v1", {71'b0, rd_valid}, 72'h1);
      end else if (t == LAT + 1) begin
        chk("cont_vend", {71'b0, rd_valid}, 72'h0);
      end
    end

    // rd_rst takes priority over a simultaneous read
    do_read(9'd5);
    rd_rst = 1'b1; rd_en = 1'b1; rd_addr = 9'd3;
    tick();
    rd_rst = 1'b0; rd_en = 1'b0;
    chk("rdrst_data", rd_data, SRV);
    chk("rdrst_valid", {71'b0, rd_valid}, 72'h0);
    for (int i = 0; i < 2; i++) tick();
    chk("rdrst_discard_v", {71'b0, rd_valid}, 72'h0);
    chk("rdrst_discard_d", rd_data, SRV);

    // address extremes
    do_write(9'd511, 8'hFF, W511);
    do_write(9'd0, 8'hFF, W0);
    do_read(9'd511);
    chk("addr511", rd_data, W511);
    do_read(9'd0);
    chk("addr0", rd_data, W0);

    // regce behaviour
    do_write(9'd1, 8'hFF, W1);
`ifdef BRAM_SDP_DOREG_EN
    begin
      int pulses;
      pulses = 0;
      regce = 1'b0;
      rd_en = 1'b1; rd_addr = 9'd1;
      tick();
      rd_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (rd_valid) pulses++;
      end
      chk("regce_stall_v", {71'b0, rd_valid}, 72'h0);
      regce = 1'b1;
      tick();
      chk("regce_go_d", rd_data, W1);
      chk("regce_go_v", {71'b0, rd_valid}, 72'h1);
      if (rd_valid) pulses++;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (rd_valid) pulses++;
      end
      chk("regce_pulses", 72'(pulses), 72'd1);
      // a held output keeps rd_valid, then no second pulse follows
      do_read(9'd5);
      regce = 1'b0;
      tick();
      chk("regce_hold_v", {71'b0, rd_valid}, 72'h1);
      chk("regce_hold_d", rd_data, D24);
      regce = 1'b1;
      tick();
      chk("regce_norepulse", {71'b0, rd_valid}, 72'h0);
    end
`else
    regce = 1'b0;
    do_read(9'd1);
    chk("regce_ignored_d", rd_data, W1);
    chk("regce_ignored_v", {71'b0, rd_valid}, 72'h1);
    regce = 1'b1;
`endif

    // reset in the middle of a read
    rd_en = 1'b1; rd_addr = 9'd5;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("mid_rst_data", rd_data, SRV);
    chk("mid_rst_valid", {71'b0, rd_valid}, 72'h0);
    chk("mid_rst_coll", {71'b0, collision}, 72'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int late;
      late = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (rd_valid) late++;
      end
      chk("mid_rst_nopulse", 72'(late), 72'd0);
    end
    do_read(9'd5);
    chk("mid_rst_mem_kept", rd_data, D24);
    chk("mid_rst_read_ok", {71'b0, rd_valid}, 72'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
